// File: rtl/sseg_pkg.sv
// ---------------------------------------------------------------------------
// sseg_pkg
// Shared constants, types and helpers for the 8-digit seven-segment scan
// engine (sseg_scan_mux and its timer).
//
// Contents:
//   NUM_DIGITS    number of multiplexed digits
//   SEG_BLANK     cathode pattern with every segment off (active-low)
//   AN_OFF        anode pattern with every digit off (active-low)
//   seg_t         one digit's segment pattern, bit 7 = dp
//   digit_idx_t   index of the digit currently being scanned
//   an_for_digit  active-low one-hot anode pattern for a digit index
// ---------------------------------------------------------------------------
package sseg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef logic [7:0] seg_t;
  typedef logic [2:0] digit_idx_t;

  // Anode pattern with only the selected digit driven low.
  function automatic logic [7:0] an_for_digit(input digit_idx_t idx);
    logic [7:0] onehot;
    onehot = 8'h01 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// ---------------------------------------------------------------------------
// sseg_scan_timer
// Owns every counter of the scan engine: the per-slot tick counter, the digit
// index, the frame counter that paces blinking, the blink phase and the
// free-running PWM counter. Everything downstream is pure decode of these.
//
// Ports:
//   clk              system clock
//   reset            asynchronous, active-high reset; clears all counters
//   slot_start       tick counter is 0 (first cycle of a digit slot)
//   frame_start_int  first cycle of digit 0's slot (first cycle of a frame)
//   in_dead          current cycle is inside the anti-ghosting dead window
//   digit_idx        digit currently being scanned, 0..7
//   pwm_cnt          free-running 4-bit PWM phase
//   blink_phase      1 = blinking digits are in their dark half-period
//
// Parameter constraints: DIGIT_TICKS >= DEAD_TICKS + 2, BLINK_FRAMES >= 1.
// ---------------------------------------------------------------------------
module sseg_scan_timer
  import sseg_pkg::*;
#(
  parameter int DIGIT_TICKS  = 12500,
  parameter int DEAD_TICKS   = 64,
  parameter int BLINK_FRAMES = 250
) (
  input  logic       clk,
  input  logic       reset,
  output logic       slot_start,
  output logic       frame_start_int,
  output logic       in_dead,
  output digit_idx_t digit_idx,
  output logic [3:0] pwm_cnt,
  output logic       blink_phase
);

  // Counter widths never drop below one bit so degenerate parameter values
  // still elaborate.
  localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] DEAD_LIM   = TW'(DEAD_TICKS);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [TW-1:0] tick_cnt;
  logic [FW-1:0] frame_cnt;

  logic tick_wrap;
  logic digit_wrap;
  logic frame_wrap;

  // Wrap chain: tick -> digit -> frame -> blink phase.
  assign tick_wrap  = (tick_cnt == TICK_LAST);
  assign digit_wrap = tick_wrap && (digit_idx == 3'd7);
  assign frame_wrap = digit_wrap && (frame_cnt == FRAME_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt    <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;

      if (tick_wrap) begin
        tick_cnt  <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end

      // blink_phase only moves on the digit 7 -> 0 wrap, so the new phase is
      // visible from the very first cycle of a frame and never mid-frame.
      if (digit_wrap) begin
        if (frame_wrap) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  assign slot_start      = (tick_cnt == '0);
  assign frame_start_int = slot_start && (digit_idx == 3'd0);

  // With no dead time the comparison would be constant, so drop it.
  generate
    if (DEAD_TICKS == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (tick_cnt < DEAD_LIM);
    end
  endgenerate

endmodule

// File: rtl/sseg_scan_mux.sv
// ---------------------------------------------------------------------------
// sseg_scan_mux
// Time-multiplexed 8-digit seven-segment scan engine. Latches the eight
// segment patterns, brightness and blink enables once per frame, then scans
// the digits one slot at a time with a leading dead window, 16-level PWM and
// per-digit blink.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset; blanks outputs at once
//   in0..in7     segment patterns, active-low, bit 7 = dp, in0 = rightmost
//   brightness   0 = 1/16 duty ... 15 = full duty
//   blink_en     bit i = 1 makes digit i blink
//   sseg         cathode pattern, active-low
//   an           anode enables, active-low, one-hot-low when lit
//   frame_start  high for the first cycle of digit 0's slot
//
// an and sseg are registered together, one clock after the counter state
// they decode, so the cathodes never change while another digit's anode is
// on.
// ---------------------------------------------------------------------------
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int DIGIT_TICKS  = 12500,
  parameter int DEAD_TICKS   = 64,
  parameter int BLINK_FRAMES = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in7,
  input  logic [7:0] in6,
  input  logic [7:0] in5,
  input  logic [7:0] in4,
  input  logic [7:0] in3,
  input  logic [7:0] in2,
  input  logic [7:0] in1,
  input  logic [7:0] in0,
  input  logic [3:0] brightness,
  input  logic [7:0] blink_en,
  output logic [7:0] sseg,
  output logic [7:0] an,
  output logic       frame_start
);

  logic       slot_start;
  logic       frame_start_int;
  logic       in_dead;
  digit_idx_t digit_idx;
  logic [3:0] pwm_cnt;
  logic       blink_phase;

  sseg_scan_timer #(
    .DIGIT_TICKS (DIGIT_TICKS),
    .DEAD_TICKS  (DEAD_TICKS),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk            (clk),
    .reset          (reset),
    .slot_start     (slot_start),
    .frame_start_int(frame_start_int),
    .in_dead        (in_dead),
    .digit_idx      (digit_idx),
    .pwm_cnt        (pwm_cnt),
    .blink_phase    (blink_phase)
  );

  // Slot boundaries carry no extra meaning here beyond the dead window.
  logic slot_start_unused;
  assign slot_start_unused = slot_start;

  // -------------------------------------------------------------------------
  // Frame shadow registers
  // -------------------------------------------------------------------------
  seg_t       shadow_pat [NUM_DIGITS];
  logic [3:0] shadow_bright;
  logic [7:0] shadow_blink;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_pat[i] <= '0;
      end
      shadow_bright <= 4'd0;
      shadow_blink  <= 8'd0;
    end else if (frame_start_int) begin
      shadow_pat[0] <= in0;
      shadow_pat[1] <= in1;
      shadow_pat[2] <= in2;
      shadow_pat[3] <= in3;
      shadow_pat[4] <= in4;
      shadow_pat[5] <= in5;
      shadow_pat[6] <= in6;
      shadow_pat[7] <= in7;
      shadow_bright <= brightness;
      shadow_blink  <= blink_en;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  // In the latch cycle the shadows still hold the previous frame, so the
  // values being latched are used directly; otherwise a zero dead time would
  // show one cycle of the old frame on digit 0.
  seg_t       live_pat;
  seg_t       cur_pat;
  logic [3:0] cur_bright;
  logic [7:0] cur_blink;
  logic       lit;

  always_comb begin
    live_pat = in0;
    case (digit_idx)
      3'd0:    live_pat = in0;
      3'd1:    live_pat = in1;
      3'd2:    live_pat = in2;
      3'd3:    live_pat = in3;
      3'd4:    live_pat = in4;
      3'd5:    live_pat = in5;
      3'd6:    live_pat = in6;
      default: live_pat = in7;
    endcase
  end

  always_comb begin
    cur_pat    = shadow_pat[digit_idx];
    cur_bright = shadow_bright;
    cur_blink  = shadow_blink;
    if (frame_start_int) begin
      cur_pat    = live_pat;
      cur_bright = brightness;
      cur_blink  = blink_en;
    end
  end

  assign lit = !in_dead
            && (pwm_cnt <= cur_bright)
            && !(cur_blink[digit_idx] && blink_phase);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an   <= AN_OFF;
      sseg <= SEG_BLANK;
    end else if (lit) begin
      an   <= an_for_digit(digit_idx);
      sseg <= cur_pat;
    end else begin
      an   <= AN_OFF;
      sseg <= SEG_BLANK;
    end
  end

  // The counters sit at the frame-start state throughout reset; masking keeps
  // the pulse low until reset is released.
  assign frame_start = frame_start_int & ~reset;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_sseg_scan_mux
// Directed bench for sseg_scan_mux. Three instances with different timing
// parameters share clock, reset and inputs; one is selected at a time for
// checking.
//   dut_a: DIGIT_TICKS=8,  DEAD_TICKS=1, BLINK_FRAMES=2   (reset, scan, tear, blink)
//   dut_b: DIGIT_TICKS=32, DEAD_TICKS=0, BLINK_FRAMES=250 (PWM duty)
//   dut_c: DIGIT_TICKS=8,  DEAD_TICKS=3, BLINK_FRAMES=2   (dead time)
// ---------------------------------------------------------------------------
module tb_sseg_scan_mux;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic [3:0] brightness;
  logic [7:0] blink_en;

  logic [7:0] sseg_a, an_a, sseg_b, an_b, sseg_c, an_c;
  logic       fs_a, fs_b, fs_c;

  sseg_scan_mux #(.DIGIT_TICKS(8), .DEAD_TICKS(1), .BLINK_FRAMES(2)) dut_a (
    .clk(clk), .reset(reset),
    .in7(in7), .in6(in6), .in5(in5), .in4(in4),
    .in3(in3), .in2(in2), .in1(in1), .in0(in0),
    .brightness(brightness), .blink_en(blink_en),
    .sseg(sseg_a), .an(an_a), .frame_start(fs_a)
  );

  sseg_scan_mux #(.DIGIT_TICKS(32), .DEAD_TICKS(0), .BLINK_FRAMES(250)) dut_b (
    .clk(clk), .reset(reset),
    .in7(in7), .in6(in6), .in5(in5), .in4(in4),
    .in3(in3), .in2(in2), .in1(in1), .in0(in0),
    .brightness(brightness), .blink_en(blink_en),
    .sseg(sseg_b), .an(an_b), .frame_start(fs_b)
  );

  sseg_scan_mux #(.DIGIT_TICKS(8), .DEAD_TICKS(3), .BLINK_FRAMES(2)) dut_c (
    .clk(clk), .reset(reset),
    .in7(in7), .in6(in6), .in5(in5), .in4(in4),
    .in3(in3), .in2(in2), .in1(in1), .in0(in0),
    .brightness(brightness), .blink_en(blink_en),
    .sseg(sseg_c), .an(an_c), .frame_start(fs_c)
  );

  // Selected instance under check.
  int         sel;
  logic [7:0] an_s, sseg_s;
  logic       fs_s;

  always_comb begin
    an_s   = an_a;
    sseg_s = sseg_a;
    fs_s   = fs_a;
    case (sel)
      1: begin an_s = an_b; sseg_s = sseg_b; fs_s = fs_b; end
      2: begin an_s = an_c; sseg_s = sseg_c; fs_s = fs_c; end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected per-digit pattern and anode, hand-written.
  typedef struct {
    logic [7:0] pat;
    logic [7:0] exp_an;
  } scan_vec_t;

  scan_vec_t tbl [8];

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    in0 = tbl[0].pat; in1 = tbl[1].pat; in2 = tbl[2].pat; in3 = tbl[3].pat;
    in4 = tbl[4].pat; in5 = tbl[5].pat; in6 = tbl[6].pat; in7 = tbl[7].pat;
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk({tag, " rst an"},   an_s,   8'hFF);
    chk({tag, " rst sseg"}, sseg_s, 8'hFF);
    chk({tag, " rst fs"},   fs_s,   1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Walks one full frame starting in the frame's first cycle. Expected output
  // for the counter state j appears one clock later: lit when past the dead
  // window, the PWM phase (j mod 16, frames are multiples of 16 long) is
  // within the frame's latched brightness and the digit is not blanked.
  // exp_lit is the hand-computed lit-cycle count per non-blanked slot.
  task automatic scan_frame(input string tag, input int ticks, input int dead,
                            input logic [3:0] bright, input logic [7:0] dark,
                            input int exp_lit, input int poke_k,
                            input int poke_sel, input logic [7:0] poke_val);
    int         slot, t, lit_cnt;
    logic       lit;
    logic [7:0] e_an, e_seg;
    lit_cnt = 0;
    for (int j = 0; j < 8 * ticks; j++) begin
      slot = j / ticks;
      t    = j % ticks;
      chk($sformatf("%s j%0d frame_start", tag, j), fs_s, (j == 0));
      if (j == poke_k) begin
        case (poke_sel)
          0: in5 = poke_val;
          1: blink_en = poke_val;
          default: brightness = poke_val[3:0];
        endcase
      end
      @(negedge clk);
      lit   = (t >= dead) && ((j % 16) <= int'(bright)) && !dark[slot];
      e_an  = lit ? tbl[slot].exp_an : 8'hFF;
      e_seg = lit ? tbl[slot].pat    : 8'hFF;
      chk($sformatf("%s j%0d an", tag, j),   an_s,   e_an);
      chk($sformatf("%s j%0d sseg", tag, j), sseg_s, e_seg);
      if (an_s != 8'hFF) lit_cnt++;
      if (t == ticks - 1) begin
        chk($sformatf("%s slot%0d lit count", tag, slot), lit_cnt,
            dark[slot] ? 0 : exp_lit);
        lit_cnt = 0;
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit found;

    tbl[0] = '{8'hC0, 8'hFE};
    tbl[1] = '{8'hF9, 8'hFD};
    tbl[2] = '{8'hA4, 8'hFB};
    tbl[3] = '{8'hB0, 8'hF7};
    tbl[4] = '{8'h99, 8'hEF};
    tbl[5] = '{8'h92, 8'hDF};
    tbl[6] = '{8'h82, 8'hBF};
    tbl[7] = '{8'h80, 8'h7F};

    reset      = 1'b0;
    sel        = 0;
    brightness = 4'd15;
    blink_en   = 8'h00;
    drive_inputs();

    // Power-on reset: every instance blank, no frame pulse.
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("por an_a", an_a, 8'hFF);   chk("por sseg_a", sseg_a, 8'hFF); chk("por fs_a", fs_a, 1'b0);
    chk("por an_b", an_b, 8'hFF);   chk("por sseg_b", sseg_b, 8'hFF); chk("por fs_b", fs_b, 1'b0);
    chk("por an_c", an_c, 8'hFF);   chk("por sseg_c", sseg_c, 8'hFF); chk("por fs_c", fs_c, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("por release fs_a", fs_a, 1'b1);

    // Reset while digit 3 is lit blanks the outputs immediately.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (an_a == 8'hF7) found = 1'b1;
    end
    chk("reach digit3 lit", found, 1'b1);
    reset = 1'b1;
    #1;
    chk("midslot rst an",   an_a,   8'hFF);
    chk("midslot rst sseg", sseg_a, 8'hFF);
    chk("midslot rst fs",   fs_a,   1'b0);
    @(negedge clk);
    chk("midslot hold an", an_a, 8'hFF);
    reset = 1'b0;
    #1;
    chk("midslot release fs", fs_a, 1'b1);
    chk("midslot release an", an_a, 8'hFF);

    // Scan order, then a mid-frame in5 change that must wait a frame.
    scan_frame("scan f0", 8, 1, 4'd15, 8'h00, 7, -1, 0, 8'h00);
    scan_frame("tear f1", 8, 1, 4'd15, 8'h00, 7, 18, 0, 8'h00);
    tbl[5].pat = 8'h00;
    scan_frame("tear f2", 8, 1, 4'd15, 8'h00, 7, -1, 0, 8'h00);

    // Blink with BLINK_FRAMES=2: digit 0 dark in frames 2-3 and 6. blink_en
    // widened to 0x81 late in frame 2 only reaches the display from frame 3.
    blink_en = 8'h01;
    apply_reset("blink");
    scan_frame("blink f0", 8, 1, 4'd15, 8'h00, 7, -1, 0, 8'h00);
    scan_frame("blink f1", 8, 1, 4'd15, 8'h00, 7, -1, 0, 8'h00);
    scan_frame("blink f2", 8, 1, 4'd15, 8'h01, 7, 60, 1, 8'h81);
    scan_frame("blink f3", 8, 1, 4'd15, 8'h81, 7, -1, 0, 8'h00);
    scan_frame("blink f4", 8, 1, 4'd15, 8'h00, 7, -1, 0, 8'h00);
    scan_frame("blink f5", 8, 1, 4'd15, 8'h00, 7, -1, 0, 8'h00);
    scan_frame("blink f6", 8, 1, 4'd15, 8'h81, 7, -1, 0, 8'h00);

    // PWM on dut_b: brightness 0 -> 2 lit per 32-cycle slot, 7 -> 16, 15 -> 32.
    // Each brightness change lands mid-frame and applies from the next frame.
    sel        = 1;
    blink_en   = 8'h00;
    brightness = 4'd0;
    apply_reset("pwm");
    chk("pwm release fs", fs_s, 1'b1);
    scan_frame("pwm b0",  32, 0, 4'd0,  8'h00, 2,  40,  2, 8'h07);
    scan_frame("pwm b7",  32, 0, 4'd7,  8'h00, 16, 100, 2, 8'h0F);
    scan_frame("pwm b15", 32, 0, 4'd15, 8'h00, 32, -1,  0, 8'h00);

    // Dead time on dut_c; digit 3 all-ones: anode active, segments dark.
    sel        = 2;
    tbl[3].pat = 8'hFF;
    drive_inputs();
    apply_reset("dead");
    scan_frame("dead f0", 8, 3, 4'd15, 8'h00, 5, -1, 0, 8'h00);
    scan_frame("dead f1", 8, 3, 4'd15, 8'h00, 5, -1, 0, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sseg_scan_mux.md
Name: sseg_scan_mux

Overview:
Time-multiplexed 8-digit seven-segment scan engine that sits directly downstream of the LED multiplexing MMIO core. It takes the eight per-digit segment patterns held in that core's data registers and drives the board's shared cathode bus and per-digit anodes. Adds tear-free frame latching, anti-ghosting dead time, 16-level PWM brightness and per-digit blink.

Parameters:
DIGIT_TICKS, 12500, clk cycles per digit slot (100 MHz gives 8 kHz slot rate, 1 kHz frame); must be >= DEAD_TICKS+2
DEAD_TICKS, 64, cycles at the start of each slot with all anodes off (anti-ghosting)
BLINK_FRAMES, 250, frames per blink half-period (about 4 Hz at defaults); must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in7..in0  input  8 each  segment patterns, active-low, bit 7 = dp; in0 is the rightmost digit
brightness  input  4  0 = 1/16 duty ... 15 = full duty
blink_en  input  8  bit i = 1 makes digit i blink
sseg  output  8  cathode pattern, active-low
an  output  8  anode enables, active-low, one-hot-low when lit
frame_start  output  1  one-cycle pulse when digit 0's slot begins

Behaviour:
- Reset (async, active-high): an = 8'hFF, sseg = 8'hFF, frame_start = 0. All counters, shadow registers and blink_phase are cleared. A reset asserted mid-slot blanks the outputs immediately, with no glitch to a lit state.
- tick_cnt counts 0..DIGIT_TICKS-1 and wraps. On wrap, digit_idx increments 0..7 and wraps. On digit_idx wrap 7->0, frame_cnt increments 0..BLINK_FRAMES-1. On frame_cnt wrap, blink_phase toggles.
- pwm_cnt is a free-running 4-bit counter that increments every clk and wraps 15->0.
- Frame latch: in the cycle where tick_cnt = 0 and digit_idx = 0, in0..in7, brightness and blink_en are copied into shadow registers. The display uses only the shadow values, so mid-frame input changes never tear a frame. frame_start pulses in that same cycle.
- Digit i is lit when all of the following hold:
  - tick_cnt >= DEAD_TICKS
  - pwm_cnt <= shadow brightness
  - NOT (shadow blink_en[i] AND blink_phase)
- When lit: an = ~(1 << digit_idx) and sseg = shadow pattern of digit_idx.
- When not lit: an = 8'hFF and sseg = 8'hFF.
- Outputs are registered with exactly 1 clk latency from counter state. an and sseg update in the same cycle; sseg never changes while an is active-low for a different digit.
- brightness = 15 gives the full post-dead-time window. brightness = 0 lights 1 cycle in 16.
- Boundary conditions:
  - Brightness or blink_en changes take effect only at the next frame start.
  - blink_phase toggles exactly at a frame boundary, never mid-frame.
  - An all-ones pattern with the anode active is legal: the digit is simply dark.

Decomposition:
- Package sseg_pkg holds:
  - NUM_DIGITS = 8
  - SEG_BLANK = 8'hFF
  - AN_OFF = 8'hFF
  - typedef seg_t (logic [7:0])
  - typedef digit_idx_t (logic [2:0])
- One sub-module, sseg_scan_timer, owns tick_cnt, digit_idx, frame_cnt, blink_phase and pwm_cnt. It outputs slot_start, frame_start_int, in_dead, digit_idx, pwm_cnt and blink_phase.
- The top level holds the shadow registers and the output decode/register.

Test Plan:
1. Reset mid-slot. Use DIGIT_TICKS=8, DEAD_TICKS=1, brightness=15; assert reset while digit 3 is lit -> an = 8'hFF and sseg = 8'hFF in the same cycle; after release, frame_start pulses on the first cycle, and digit 0 lights 2 cycles later.
2. Scan order. Set in0..in7 = 8'hC0, 8'hF9, ... 8'h80 with brightness=15 -> an steps FE, FD, FB ... 7F, each lit for 7 of 8 cycles with 1 cycle of FF between slots, and sseg matches the digit every lit cycle.
3. No tearing. Change in5 from 8'h92 to 8'h00 during digit 2's slot -> digit 5 still shows 8'h92 that frame and 8'h00 from the next frame.
4. PWM. With brightness=0 and then brightness=7, using DIGIT_TICKS=32, DEAD_TICKS=0 -> the lit-cycle count per slot is 2 and 16 respectively; an is never low while pwm_cnt > brightness.
5. Blink. With BLINK_FRAMES=2 and blink_en=8'h01 -> digit 0 is dark for frames 2-3, lit for frames 4-5, and so on; digits 1-7 are unaffected; the blink toggle coincides with frame_start.
6. Dead time. With DEAD_TICKS=3 and brightness=15 -> an = FF for the first 3 cycles of every slot, measured at 1-cycle output latency.
